mul_issue_ctrl: RTL

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/return controller for a shared 3-stage multiplier: arbitrates two requesters,
// tracks in-flight ops with credits and a tag FIFO. Define MUL_RR_ARB_EN for round-robin arbitration.
module mul_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        REQ0_VALID_SD,
  input  logic [1:0]  REQ0_OP_SD,
  input  logic [31:0] REQ0_RS1_SD,
  input  logic [31:0] REQ0_RS2_SD,
  output logic        REQ0_READY_SD,
  input  logic        REQ1_VALID_SD,
  input  logic [1:0]  REQ1_OP_SD,
  input  logic [31:0] REQ1_RS1_SD,
  input  logic [31:0] REQ1_RS2_SD,
  output logic        REQ1_READY_SD,
  output logic        X0_PUSH_SX0,
  output logic [31:0] X0_RS1_RX0,
  output logic [31:0] X0_RS2_RX0,
  output logic [1:0]  X0_SIGNED_RX0,
  output logic        X0_SELECT_MSB_RX0,
  input  logic        X0_FULL_SX0,
  input  logic        X2_EMPTY_SX2,
  input  logic [31:0] X2_RES_RX2,
  output logic        X2_POP_SX2,
  output logic        RES0_VALID_RX3,
  output logic        RES1_VALID_RX3,
  output logic [31:0] RES_DATA_RX3,
  input  logic        FLUSH0_SD,
  output logic        BUSY_SX
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam logic [CW-1:0] CRED_MAX = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FULL, S_DRAIN} state_t;

  state_t                  state;
  logic [CW-1:0]           credits;
  logic [CW-1:0]           cred_nxt;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [MAX_INFLIGHT-1:0] tag_id;
  logic [MAX_INFLIGHT-1:0] tag_killed;
  logic [MAX_INFLIGHT-1:0] tag_occ;
  logic [MAX_INFLIGHT-1:0] killed_nxt;
  logic [MAX_INFLIGHT-1:0] occ_nxt;
  logic                    kill_pending_nxt;

  logic                    req0_elig;
  logic                    req1_elig;
  logic                    can_issue;
  logic                    pick1;
  logic                    issue;
  logic                    pop_tag;
  logic                    head_id;
  logic                    head_killed;
  logic [1:0]              op_sel;
  logic [2:0]              op_dec;

  // {select_msb, rs1_signed, rs2_signed}
  function automatic logic [2:0] decode_op(input logic [1:0] op);
    case (op)
      2'd0:    return 3'b0_11;
      2'd1:    return 3'b1_11;
      2'd2:    return 3'b1_10;
      default: return 3'b1_00;
    endcase
  endfunction

  // Credits saturate at the maximum so stale pops after reset are harmless.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c,
                                                input logic dec, input logic inc);
    if (dec && !inc) return c - CW'(1);
    if (inc && !dec) return (c == CRED_MAX) ? c : c + CW'(1);
    return c;
  endfunction

  // Stage SD: arbitration and issue into x0
  assign req0_elig = REQ0_VALID_SD & ~FLUSH0_SD & (state != S_DRAIN);
  assign req1_elig = REQ1_VALID_SD;
  assign can_issue = ~reset & ~X0_FULL_SX0 & (credits != '0);

`ifdef MUL_RR_ARB_EN
  logic prio;
  assign pick1 = req1_elig & (~req0_elig | prio);
`else
  assign pick1 = req1_elig & ~req0_elig;
`endif

  assign issue         = can_issue & (req0_elig | req1_elig);
  assign REQ0_READY_SD = issue & ~pick1;
  assign REQ1_READY_SD = issue & pick1;
  assign X0_PUSH_SX0   = issue;

  assign op_sel            = pick1 ? REQ1_OP_SD : REQ0_OP_SD;
  assign op_dec            = decode_op(op_sel);
  assign X0_SELECT_MSB_RX0 = op_dec[2];
  assign X0_SIGNED_RX0     = op_dec[1:0];
  assign X0_RS1_RX0        = pick1 ? REQ1_RS1_SD : REQ0_RS1_SD;
  assign X0_RS2_RX0        = pick1 ? REQ1_RS2_SD : REQ0_RS2_SD;

  // Stage SX2: result pop and tag lookup
  assign X2_POP_SX2  = ~X2_EMPTY_SX2;
  assign pop_tag     = X2_POP_SX2 & tag_occ[rd_ptr];
  assign head_id     = tag_id[rd_ptr];
  assign head_killed = tag_killed[rd_ptr] | (FLUSH0_SD & ~head_id);
  assign cred_nxt    = credit_next(credits, issue, X2_POP_SX2);
  assign BUSY_SX     = (credits != CRED_MAX);

  always_comb begin
    occ_nxt    = tag_occ;
    killed_nxt = tag_killed;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (FLUSH0_SD && tag_occ[i] && !tag_id[i]) killed_nxt[i] = 1'b1;
    end
    if (pop_tag) occ_nxt[rd_ptr] = 1'b0;
    if (issue) begin
      occ_nxt[wr_ptr]    = 1'b1;
      killed_nxt[wr_ptr] = FLUSH0_SD & ~pick1;
    end
    kill_pending_nxt = |(occ_nxt & killed_nxt);
  end

  always_ff @(posedge clk) begin
    if (issue) tag_id[wr_ptr] <= pick1;
  end

  // Stage RX3: registered result return and controller state
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      credits        <= CRED_MAX;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tag_occ        <= '0;
      tag_killed     <= '0;
      RES0_VALID_RX3 <= 1'b0;
      RES1_VALID_RX3 <= 1'b0;
      RES_DATA_RX3   <= '0;
`ifdef MUL_RR_ARB_EN
      prio           <= 1'b0;
`endif
    end else begin
      credits    <= cred_nxt;
      tag_occ    <= occ_nxt;
      tag_killed <= killed_nxt;
      if (issue)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_tag) rd_ptr <= rd_ptr + PW'(1);
      RES0_VALID_RX3 <= pop_tag & ~head_killed & ~head_id;
      RES1_VALID_RX3 <= pop_tag & ~head_killed & head_id;
      if (X2_POP_SX2) RES_DATA_RX3 <= X2_RES_RX2;
`ifdef MUL_RR_ARB_EN
      if (issue) prio <= ~pick1;
`endif
      if (kill_pending_nxt)        state <= S_DRAIN;
      else if (cred_nxt == CRED_MAX) state <= S_IDLE;
      else if (cred_nxt == '0)     state <= S_FULL;
      else                         state <= S_ISSUE;
    end
  end

endmodule
